// File: rtl/addsub_rr_arbiter.sv
// Round-robin front end that shares one external WIDTH-bit adder-subtractor
// between two valid/ready requesters and returns tagged, registered results.
module addsub_rr_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sel,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic             au_sel,
    input  logic [WIDTH-1:0] au_sum,
    input  logic             au_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t           state_reg;
    logic             last_grant_reg;
    logic             id_reg;
    logic [WIDTH-1:0] au_a_reg;
    logic [WIDTH-1:0] au_b_reg;
    logic             au_sel_reg;
    logic             rsp_valid_reg;
    logic             rsp_id_reg;
    logic [WIDTH-1:0] rsp_sum_reg;
    logic             rsp_cout_reg;
    logic             busy_reg;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_sel;
    logic [WIDTH-1:0] req_a [2];
    logic [WIDTH-1:0] req_b [2];
    logic             grant_id;
    logic             accept;

    assign req_valid = {req1_valid, req0_valid};
    assign req_sel   = {req1_sel, req0_sel};
    assign req_a[0]  = req0_a;
    assign req_a[1]  = req1_a;
    assign req_b[0]  = req0_b;
    assign req_b[1]  = req1_b;

    // On a tie the requester that did not win last time gets the unit.
    always_comb begin
        grant_id = 1'b0;
        if (req_valid == 2'b11) begin
            grant_id = ~last_grant_reg;
        end else if (req_valid == 2'b10) begin
            grant_id = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = (state_reg == IDLE) && req_valid[gi] && (grant_id == 1'(gi));
        end
    endgenerate

    assign accept     = |req_ready;
    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            id_reg         <= 1'b0;
            au_a_reg       <= '0;
            au_b_reg       <= '0;
            au_sel_reg     <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_sum_reg    <= '0;
            rsp_cout_reg   <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        au_a_reg       <= req_a[grant_id];
                        au_b_reg       <= req_b[grant_id];
                        au_sel_reg     <= req_sel[grant_id];
                        id_reg         <= grant_id;
                        last_grant_reg <= grant_id;
                        busy_reg       <= 1'b1;
                        state_reg      <= EXEC;
                    end
                end
                EXEC: begin
                    // The shared unit has had a full cycle to settle on au_*.
                    rsp_sum_reg   <= au_sum;
                    rsp_cout_reg  <= au_cout;
                    rsp_id_reg    <= id_reg;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign au_a      = au_a_reg;
    assign au_b      = au_b_reg;
    assign au_sel    = au_sel_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_cout  = rsp_cout_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Directed bench for addsub_rr_arbiter; models the external add/sub unit
// and checks handshakes, latency, arbitration, backpressure and reset.
module tb_addsub_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_sel;
    logic [3:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_sel;
    logic [3:0] req1_a, req1_b;
    logic [3:0] au_a, au_b, au_sum;
    logic       au_sel, au_cout;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
    logic [3:0] rsp_sum;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    // External combinational adder-subtractor: A + ~B + 1 for subtraction.
    always_comb begin
        {au_cout, au_sum} = {1'b0, au_a} + {1'b0, (au_sel ? ~au_b : au_b)} + 5'(au_sel);
    end

    addsub_rr_arbiter #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .au_a(au_a), .au_b(au_b), .au_sel(au_sel), .au_sum(au_sum), .au_cout(au_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .busy(busy)
    );

    // Drives one operation with rsp_ready=1 and returns what the DUT reported.
    task automatic run_op(input logic id, input logic [3:0] a, input logic [3:0] b, input logic sel,
                          output logic [3:0] sum, output logic cout, output logic rid,
                          output int lat, output bit timed_out);
        bit acc;
        bit seen;
        int n;
        acc = 0; seen = 0; lat = 0; timed_out = 0; sum = '0; cout = 0; rid = 0;
        rsp_ready = 1'b1;
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
        end
        n = 0;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = (id == 1'b0) ? req0_ready : req1_ready;
            @(posedge clk); #1;
            n++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        lat = 1;
        while (acc && !seen && n < 20) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1; sum = rsp_sum; cout = rsp_cout; rid = rsp_id;
            end else begin
                lat++;
            end
            @(posedge clk); #1;
            n++;
        end
        timed_out = !seen;
        $display("txn req%0d a=%0d b=%0d sel=%0d -> id=%0d sum=%0d cout=%0d lat=%0d timeout=%0d",
                 id, a, b, sel, rid, sum, cout, lat, timed_out);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
        rsp_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if ({au_a, au_b, au_sel} !== 9'd0) $display("FAIL reset_au: got a=%0d b=%0d sel=%b want 0", au_a, au_b, au_sel); else pass_cnt++;
        total_cnt++; if ({rsp_sum, rsp_cout, rsp_id} !== 6'd0) $display("FAIL reset_rsp: got sum=%0d cout=%b id=%b want 0", rsp_sum, rsp_cout, rsp_id); else pass_cnt++;
        total_cnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready: got %b%b want 00", req1_ready, req0_ready); else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_add();
        $display("txn req0 7+5 (cycle-accurate)");
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd5; req0_sel = 1'b0;
        @(negedge clk);
        total_cnt++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL add_ready: got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready); else pass_cnt++;
        @(posedge clk); #1;
        req0_valid = 1'b0; req0_a = 4'hF;
        @(negedge clk);
        total_cnt++; if ({au_a, au_b, au_sel} !== {4'd7, 4'd5, 1'b0}) $display("FAIL add_au: got a=%0d b=%0d sel=%b want 7 5 0", au_a, au_b, au_sel); else pass_cnt++;
        total_cnt++; if ({rsp_valid, busy} !== 2'b01) $display("FAIL add_exec: got valid=%b busy=%b want 0 1", rsp_valid, busy); else pass_cnt++;
        @(posedge clk); #1;
        @(negedge clk);
        total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL add_latency: got rsp_valid=%b want 1", rsp_valid); else pass_cnt++;
        total_cnt++; if ({rsp_id, rsp_sum, rsp_cout} !== {1'b0, 4'd12, 1'b0}) $display("FAIL add_result: got id=%b sum=%0d cout=%b want 0 12 0", rsp_id, rsp_sum, rsp_cout); else pass_cnt++;
        @(posedge clk); #1;
        @(negedge clk);
        total_cnt++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL add_done: got valid=%b busy=%b want 0 0", rsp_valid, busy); else pass_cnt++;
        total_cnt++; if ({au_a, rsp_sum} !== {4'd7, 4'd12}) $display("FAIL add_hold: got au_a=%0d sum=%0d want 7 12", au_a, rsp_sum); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_subtract();
        logic [3:0] s;
        logic c, r;
        int lat;
        bit to;
        run_op(1'b1, 4'd15, 4'd10, 1'b1, s, c, r, lat, to);
        total_cnt++; if (to || {r, s, c} !== {1'b1, 4'd5, 1'b1}) $display("FAIL sub_15_10: got to=%0d id=%b sum=%0d cout=%b want 1 5 1", to, r, s, c); else pass_cnt++;
        total_cnt++; if (lat !== 2) $display("FAIL sub_latency: got %0d want 2", lat); else pass_cnt++;
        run_op(1'b1, 4'd5, 4'd7, 1'b1, s, c, r, lat, to);
        total_cnt++; if (to || {r, s, c} !== {1'b1, 4'd14, 1'b0}) $display("FAIL sub_5_7: got to=%0d id=%b sum=%0d cout=%b want 1 14 0", to, r, s, c); else pass_cnt++;
        run_op(1'b1, 4'd0, 4'd1, 1'b1, s, c, r, lat, to);
        total_cnt++; if (to || {r, s, c} !== {1'b1, 4'd15, 1'b0}) $display("FAIL sub_0_1: got to=%0d id=%b sum=%0d cout=%b want 1 15 0", to, r, s, c); else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [3:0] s;
        logic c, r;
        int lat;
        bit to;
        run_op(1'b0, 4'd15, 4'd15, 1'b0, s, c, r, lat, to);
        total_cnt++; if (to || {r, s, c} !== {1'b0, 4'd14, 1'b1}) $display("FAIL ovf_15_15: got to=%0d id=%b sum=%0d cout=%b want 0 14 1", to, r, s, c); else pass_cnt++;
    endtask

    task automatic test_contention();
        int grants [8];
        logic [5:0] rsps [4];
        int ng, nr, both_hi;
        ng = 0; nr = 0; both_hi = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd1; req0_sel = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd7; req1_sel = 1'b1;
        for (int c = 0; c < 20 && nr < 4; c++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) both_hi++;
            if (req0_ready && ng < 8) begin grants[ng] = 0; ng++; end
            if (req1_ready && ng < 8) begin grants[ng] = 1; ng++; end
            if (rsp_valid && rsp_ready) begin
                rsps[nr] = {rsp_id, rsp_sum, rsp_cout};
                $display("txn contention rsp%0d id=%0d sum=%0d cout=%0d", nr, rsp_id, rsp_sum, rsp_cout);
                nr++;
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        total_cnt++; if (both_hi !== 0) $display("FAIL cont_one_ready: got %0d cycles with both ready want 0", both_hi); else pass_cnt++;
        total_cnt++; if (nr !== 4 || ng < 4) $display("FAIL cont_count: got rsp=%0d grants=%0d want 4 4", nr, ng); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (i < ng) begin
                total_cnt++; if (grants[i] !== (i % 2)) $display("FAIL cont_grant%0d: got %0d want %0d", i, grants[i], i % 2); else pass_cnt++;
            end
            if (i < nr) begin
                total_cnt++;
                if (rsps[i] !== ((i % 2 == 0) ? {1'b0, 4'd8, 1'b0} : {1'b1, 4'd0, 1'b1}))
                    $display("FAIL cont_rsp%0d: got id/sum/cout=%h want %h", i, rsps[i], ((i % 2 == 0) ? {1'b0, 4'd8, 1'b0} : {1'b1, 4'd0, 1'b1}));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_backpressure();
        int stable_bad, rdy_bad;
        stable_bad = 0; rdy_bad = 0;
        $display("txn req0 3+4 under backpressure, req1 1+1 waiting");
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd4; req0_sel = 1'b0;
        @(negedge clk);
        total_cnt++; if (req0_ready !== 1'b1) $display("FAIL bp_accept: got %b want 1", req0_ready); else pass_cnt++;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1; req1_sel = 1'b0;
        @(negedge clk);
        total_cnt++; if (req1_ready !== 1'b0) $display("FAIL bp_exec_ready: got %b want 0", req1_ready); else pass_cnt++;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, 1'b0, 4'd7, 1'b0}) stable_bad++;
            if (req1_ready !== 1'b0) rdy_bad++;
            @(posedge clk); #1;
        end
        total_cnt++; if (stable_bad !== 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", stable_bad); else pass_cnt++;
        total_cnt++; if (rdy_bad !== 0) $display("FAIL bp_no_ready: got %0d cycles with req1_ready want 0", rdy_bad); else pass_cnt++;
        rsp_ready = 1'b1;
        @(negedge clk);
        total_cnt++; if ({rsp_valid, req1_ready} !== 2'b10) $display("FAIL bp_release: got valid=%b r1=%b want 1 0", rsp_valid, req1_ready); else pass_cnt++;
        @(posedge clk); #1;
        @(negedge clk);
        total_cnt++; if ({rsp_valid, req1_ready} !== 2'b01) $display("FAIL bp_next_accept: got valid=%b r1=%b want 0 1", rsp_valid, req1_ready); else pass_cnt++;
        total_cnt++; if (rsp_sum !== 4'd7) $display("FAIL bp_sum_hold: got %0d want 7", rsp_sum); else pass_cnt++;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        total_cnt++; if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 1'b1, 4'd2}) $display("FAIL bp_second: got valid=%b id=%b sum=%0d want 1 1 2", rsp_valid, rsp_id, rsp_sum); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        $display("txn req0 9+2 aborted by reset");
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd2; req0_sel = 1'b0;
        @(negedge clk);
        total_cnt++; if (req0_ready !== 1'b1) $display("FAIL rmid_accept: got %b want 1", req0_ready); else pass_cnt++;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL rmid_no_rsp: got valid=%b busy=%b want 0 0", rsp_valid, busy); else pass_cnt++;
        total_cnt++; if ({au_a, au_b, au_sel, rsp_sum, rsp_cout, rsp_id} !== 15'd0) $display("FAIL rmid_zero: got au_a=%0d au_b=%0d sel=%b sum=%0d cout=%b id=%b want 0", au_a, au_b, au_sel, rsp_sum, rsp_cout, rsp_id); else pass_cnt++;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_sel = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2; req1_sel = 1'b0;
        @(negedge clk);
        total_cnt++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rmid_first_tie: got r0=%b r1=%b want 1 0", req0_ready, req1_ready); else pass_cnt++;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_add();
        test_subtract();
        test_overflow();
        test_contention();
        test_backpressure();
        test_reset_midop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/addsub_rr_arbiter.md
Name: addsub_rr_arbiter

Overview:
- Shares one WIDTH-bit adder-subtractor datapath between two requesters.
- Round-robin arbitration; valid/ready handshake on both requester ports and on the single response port.
- Registers the operands into the shared unit, captures its sum/carry and returns them tagged with the requester id.
- Sits between two client blocks and the team's combinational add/sub unit, which is instantiated outside this block.

Parameters:
- WIDTH, 4, operand and result width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_sel  input  1  requester 0 op: 0 = A+B, 1 = A-B.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel: same as requester 0, for requester 1.
- au_a  output  WIDTH  operand A to the shared adder-subtractor.
- au_b  output  WIDTH  operand B to the shared adder-subtractor.
- au_sel  output  1  add/sub select to the shared unit.
- au_sum  input  WIDTH  sum from the shared unit (combinational from au_*).
- au_cout  input  1  carry-out from the shared unit.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  1  requester that issued the result.
- rsp_sum  output  WIDTH  captured sum.
- rsp_cout  output  1  captured carry-out, raw. For subtraction, 1 means A>=B (no borrow).
- busy  output  1  FSM not in IDLE.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: state=IDLE; au_a, au_b, au_sel = 0; rsp_valid=0; rsp_id=0; rsp_sum=0; rsp_cout=0; busy=0; last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational: asserted only in IDLE, only for the granted requester, only while its valid is high.
  - Only one ready is high in any cycle.
  - Grant when exactly one valid: that requester.
  - Grant when both valid: the requester other than last_grant.
  - On accept (valid & ready): register a/b/sel into au_a/au_b/au_sel; store id; update last_grant to the granted id; go to EXEC.
- EXEC (one cycle): au_* are stable. At the clock edge, capture au_sum→rsp_sum, au_cout→rsp_cout, id→rsp_id; set rsp_valid=1; go to RESP.
- RESP: rsp_* held stable while rsp_valid=1 and rsp_ready=0. On rsp_valid & rsp_ready: clear rsp_valid, go to IDLE.
- Latency: accept at cycle N → rsp_valid high from cycle N+2.
- Throughput: max one op per 3 cycles; the next accept is no earlier than the cycle after the response handshake.
- au_a, au_b, au_sel hold their last values in RESP and IDLE and change only on an accept. rsp_sum and rsp_cout also hold after the handshake.
- Requester handshake rules:
  - A requester must hold valid and operands stable until ready.
  - Operands are sampled only on the accept edge; later changes are ignored.
  - A requester that drops valid before ready is never served.
- Arithmetic: WIDTH-bit modulo. Sum wraps, carry reported separately, no saturation. The block does not recompute; it forwards the shared unit's result.
- Reset mid-operation (EXEC or RESP): the transaction is discarded, no response is produced, and all outputs return to reset values on the next edge.
- Simultaneous valids with unchanged priority: requesters alternate strictly, so neither starves.

Test Plan:
- Single add: req0 a=7, b=5, sel=0 → req0_ready at N; au_a=7, au_b=5 at N+1; rsp_valid at N+2 with id=0, sum=12, cout=0.
- Subtract with and without borrow: req1 15-10 → sum=5, cout=1, id=1. Then req1 5-7 → sum=14, cout=0. Then req1 0-1 → sum=15, cout=0.
- Overflow add: req0 15+15, sel=0 → sum=14, cout=1.
- Contention: both valid continuously from reset with distinct ops (req0 7+1, req1 7-7) → grants alternate 0,1,0,1; responses 8/cout0 then 0/cout1 in grant order.
- Response backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_* stable, no new req ready. Release → handshake, then accept next cycle.
- Reset mid-op: assert rst during EXEC → no rsp_valid; outputs zero after the reset edge. After release, the first tie grants requester 0.
